// File: rtl/rm_lane_allocator.sv
// rm_lane_allocator: allocates monitor lanes to contexts, clears them, and reports qualified rule hits round-robin
module rm_lane_allocator #(
  parameter int NUM_LANES = 5,
  parameter int NUM_RULES = 5,
  parameter int CTX_W = 8,
  localparam int LANE_W = $clog2(NUM_LANES),
  localparam int RULE_W = $clog2(NUM_RULES)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           alloc_req_i,
  input  logic [CTX_W-1:0]               alloc_ctx_i,
  output logic                           alloc_gnt_o,
  output logic [LANE_W-1:0]              alloc_lane_o,
  output logic                           alloc_full_o,
  input  logic                           free_valid_i,
  input  logic [LANE_W-1:0]              free_lane_i,
  output logic [NUM_LANES-1:0]           lane_reset_o,
  output logic [NUM_LANES-1:0]           lane_busy_o,
  input  logic [NUM_LANES*NUM_RULES-1:0] monitor_i,
  output logic                           alert_valid_o,
  input  logic                           alert_ready_i,
  output logic [LANE_W-1:0]              alert_lane_o,
  output logic [RULE_W-1:0]              alert_rule_o,
  output logic [CTX_W-1:0]               alert_ctx_o
);
  typedef enum logic [2:0] {FREE, CLR, ACTIVE, FLAGGED, REPORTED} state_t;
  state_t               st   [NUM_LANES];
  logic [CTX_W-1:0]     ctx  [NUM_LANES];
  logic [NUM_RULES-1:0] hits [NUM_LANES];
  logic [LANE_W-1:0]    ptr, free_idx, pick;
  logic [RULE_W-1:0]    pick_rule;
  logic                 free_any, pick_ok, do_gnt, accept;
  // Descending scans so the last match wins: lowest free lane, first flagged lane from ptr
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    pick_ok = 1'b0;
    pick = '0;
    pick_rule = '0;
    lane_reset_o = '0;
    lane_busy_o = '0;
    for (int k = NUM_LANES-1; k >= 0; k--) begin
      lane_reset_o[k] = st[k] == FREE || st[k] == CLR;
      lane_busy_o[k] = st[k] != FREE;
      if (st[k] == FREE) begin
        free_any = 1'b1;
        free_idx = LANE_W'(k);
      end
      if (st[(int'(ptr) + k) % NUM_LANES] == FLAGGED) begin
        pick_ok = 1'b1;
        pick = LANE_W'((int'(ptr) + k) % NUM_LANES);
      end
    end
    for (int r = NUM_RULES-1; r >= 0; r--)
      if (hits[pick][r]) pick_rule = RULE_W'(r);
  end
  assign alloc_full_o = !free_any;
  assign do_gnt = alloc_req_i && free_any && !alloc_gnt_o;
  assign accept = alert_valid_o && alert_ready_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        st[i] <= FREE;
        ctx[i] <= '0;
        hits[i] <= '0;
      end
      alloc_gnt_o <= 1'b0;
      alloc_lane_o <= '0;
      alert_valid_o <= 1'b0;
      alert_lane_o <= '0;
      alert_rule_o <= '0;
      alert_ctx_o <= '0;
      ptr <= '0;
    end else begin
      alloc_gnt_o <= do_gnt;
      if (do_gnt) alloc_lane_o <= free_idx;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (do_gnt && free_idx == LANE_W'(i)) begin
          st[i] <= CLR;
          ctx[i] <= alloc_ctx_i;
        end else if (st[i] == CLR) begin
          st[i] <= ACTIVE;
        end else if (free_valid_i && free_lane_i == LANE_W'(i) && (st[i] == ACTIVE || st[i] == REPORTED)) begin
          st[i] <= FREE;
        end else if (st[i] == ACTIVE && |monitor_i[i*NUM_RULES +: NUM_RULES]) begin
          st[i] <= FLAGGED;
          hits[i] <= monitor_i[i*NUM_RULES +: NUM_RULES];
        end else if (accept && alert_lane_o == LANE_W'(i)) begin
          st[i] <= REPORTED;
        end
      end
      if (accept) begin
        alert_valid_o <= 1'b0;
        ptr <= alert_lane_o == LANE_W'(NUM_LANES-1) ? '0 : alert_lane_o + 1'b1;
      end else if (!alert_valid_o && pick_ok) begin
        alert_valid_o <= 1'b1;
        alert_lane_o <= pick;
        alert_rule_o <= pick_rule;
        alert_ctx_o <= ctx[pick];
      end
    end
  end
endmodule

// File: tb/tb_rm_lane_allocator.sv
// tb_rm_lane_allocator: vector table, directed corner sequences and randomized run against a lane-level model
module tb_rm_lane_allocator;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, fv = 1'b0, rdy = 1'b0;
  logic [7:0]  ctx = '0;
  logic [2:0]  fl = '0;
  logic [24:0] mon = '0;
  logic        gnt, full, av;
  logic [2:0]  gl, al, ar;
  logic [7:0]  ac;
  logic [4:0]  lrst, busy;
  int n_cmp = 0, n_fail = 0;

  rm_lane_allocator dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_req_i(req), .alloc_ctx_i(ctx), .alloc_gnt_o(gnt), .alloc_lane_o(gl), .alloc_full_o(full),
    .free_valid_i(fv), .free_lane_i(fl), .lane_reset_o(lrst), .lane_busy_o(busy),
    .monitor_i(mon), .alert_valid_o(av), .alert_ready_i(rdy),
    .alert_lane_o(al), .alert_rule_o(ar), .alert_ctx_o(ac)
  );

  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [7:0] c, input logic [2:0] lane);
    req = 1'b1;
    ctx = c;
    step();
    for (int n = 0; n < 20 && !gnt; n++) step();
    chk("alloc_gnt", 32'(gnt), 32'd1);
    chk("alloc_lane", 32'(gl), 32'(lane));
    req = 1'b0;
  endtask

  typedef struct {
    logic req; logic [7:0] ctx; logic fv; logic [2:0] fl; logic [24:0] mon; logic rdy;
    logic gnt; logic [2:0] gl; logic full; logic [4:0] rst; logic [4:0] busy;
    logic av; logic [2:0] al; logic [2:0] ar; logic [7:0] ac;
  } vec_t;
  vec_t vq[$];

  // Lane-level reference: busy flag, cycles since grant, captured hits (0 = none), reported flag
  bit         m_busy[5], m_rep[5], m_gnt, m_av;
  int         m_age[5], m_hit[5], m_gl, m_al, m_ar, m_ptr;
  logic [7:0] m_ctx[5], m_ac;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_busy[i] = 0; m_rep[i] = 0; m_age[i] = 0; m_hit[i] = 0; m_ctx[i] = '0;
    end
    m_gnt = 0; m_av = 0; m_gl = 0; m_al = 0; m_ar = 0; m_ac = '0; m_ptr = 0;
  endtask

  task automatic model_step();
    bit o_busy[5], o_rep[5], dg;
    int o_age[5], o_hit[5], free_at, h;
    logic [7:0] o_ctx[5];
    o_busy = m_busy; o_rep = m_rep; o_age = m_age; o_hit = m_hit; o_ctx = m_ctx;
    free_at = -1;
    for (int i = 4; i >= 0; i--) if (!o_busy[i]) free_at = i;
    dg = req && free_at >= 0 && !m_gnt;
    if (m_av && rdy) begin
      m_rep[m_al] = 1;
      m_av = 0;
      m_ptr = (m_al + 1) % 5;
    end else if (!m_av) begin
      for (int k = 0; k < 5; k++) begin
        int j;
        j = (m_ptr + k) % 5;
        if (o_hit[j] != 0 && !o_rep[j]) begin
          h = o_hit[j];
          m_av = 1; m_al = j; m_ar = $clog2(h & -h); m_ac = o_ctx[j];
          break;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      h = int'(mon[i*5 +: 5]);
      if (dg && free_at == i) begin
        m_busy[i] = 1; m_age[i] = 0; m_hit[i] = 0; m_rep[i] = 0; m_ctx[i] = ctx;
      end else if (o_busy[i] && o_age[i] == 0) begin
        m_age[i] = 1;
      end else if (fv && int'(fl) == i && o_busy[i] && o_age[i] > 0 && (o_hit[i] == 0 || o_rep[i])) begin
        m_busy[i] = 0; m_hit[i] = 0; m_rep[i] = 0;
      end else if (o_busy[i] && o_age[i] > 0 && o_hit[i] == 0 && h != 0) begin
        m_hit[i] = h;
      end
    end
    m_gnt = dg;
    if (dg) m_gl = free_at;
  endtask

  task automatic model_check();
    logic [4:0] e_rst, e_busy;
    for (int i = 0; i < 5; i++) begin
      e_rst[i] = !m_busy[i] || m_age[i] == 0;
      e_busy[i] = m_busy[i];
    end
    chk("rnd_gnt", 32'(gnt), 32'(m_gnt));
    if (m_gnt) chk("rnd_gnt_lane", 32'(gl), 32'(m_gl));
    chk("rnd_full", 32'(full), 32'(&e_busy));
    chk("rnd_lane_reset", 32'(lrst), 32'(e_rst));
    chk("rnd_lane_busy", 32'(busy), 32'(e_busy));
    chk("rnd_alert_valid", 32'(av), 32'(m_av));
    if (m_av) begin
      chk("rnd_alert_lane", 32'(al), 32'(m_al));
      chk("rnd_alert_rule", 32'(ar), 32'(m_ar));
      chk("rnd_alert_ctx", 32'(ac), 32'(m_ac));
    end
  endtask

  initial begin
    //           req  ctx    fv   fl    mon          rdy   gnt  gl    full  rst       busy      av   al    ar    ac
    vq.push_back('{1'b1, 8'h10, 1'b0, 3'd0, 25'h0,     1'b0, 1'b1, 3'd0, 1'b0, 5'b11111, 5'b00001, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h11, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b0, 5'b11110, 5'b00001, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h11, 1'b0, 3'd0, 25'h0,     1'b0, 1'b1, 3'd1, 1'b0, 5'b11110, 5'b00011, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h12, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b0, 5'b11100, 5'b00011, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h12, 1'b0, 3'd0, 25'h0,     1'b0, 1'b1, 3'd2, 1'b0, 5'b11100, 5'b00111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h13, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b0, 5'b11000, 5'b00111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h13, 1'b0, 3'd0, 25'h0,     1'b0, 1'b1, 3'd3, 1'b0, 5'b11000, 5'b01111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h14, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b0, 5'b10000, 5'b01111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h14, 1'b0, 3'd0, 25'h0,     1'b0, 1'b1, 3'd4, 1'b1, 5'b10000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h20, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h20, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h20, 1'b1, 3'd2, 25'h0,     1'b0, 1'b0, 3'd0, 1'b0, 5'b00100, 5'b11011, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b1, 8'h20, 1'b0, 3'd0, 25'h0,     1'b0, 1'b1, 3'd2, 1'b1, 5'b00100, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h180,   1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd2, 8'h11});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd2, 8'h11});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd2, 8'h11});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd2, 8'h11});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h400,   1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b1, 3'd2, 3'd0, 8'h20});
    vq.push_back('{1'b0, 8'h00, 1'b0, 3'd0, 25'h0,     1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b11111, 1'b0, 3'd0, 3'd0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b1, 3'd1, 25'h0,     1'b0, 1'b0, 3'd0, 1'b0, 5'b00010, 5'b11101, 1'b0, 3'd0, 3'd0, 8'h00});

    #12;
    chk("reset_lane_reset", 32'(lrst), 32'h1f);
    chk("reset_lane_busy", 32'(busy), 32'h0);
    chk("reset_alert_valid", 32'(av), 32'h0);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;

    foreach (vq[v]) begin
      req = vq[v].req; ctx = vq[v].ctx; fv = vq[v].fv; fl = vq[v].fl; mon = vq[v].mon; rdy = vq[v].rdy;
      step();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vq[v].gnt));
      if (vq[v].gnt) chk($sformatf("vec%0d_gnt_lane", v), 32'(gl), 32'(vq[v].gl));
      chk($sformatf("vec%0d_full", v), 32'(full), 32'(vq[v].full));
      chk($sformatf("vec%0d_lane_reset", v), 32'(lrst), 32'(vq[v].rst));
      chk($sformatf("vec%0d_lane_busy", v), 32'(busy), 32'(vq[v].busy));
      chk($sformatf("vec%0d_alert_valid", v), 32'(av), 32'(vq[v].av));
      if (vq[v].av) begin
        chk($sformatf("vec%0d_alert_lane", v), 32'(al), 32'(vq[v].al));
        chk($sformatf("vec%0d_alert_rule", v), 32'(ar), 32'(vq[v].ar));
        chk($sformatf("vec%0d_alert_ctx", v), 32'(ac), 32'(vq[v].ac));
      end
    end
    req = 0; fv = 0; mon = '0; rdy = 0;

    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    do_alloc(8'h30, 3'd0);
    do_alloc(8'h31, 3'd1);
    do_alloc(8'h32, 3'd2);
    do_alloc(8'h33, 3'd3);
    mon = 25'h1 << 15;
    step();
    mon = '0;
    step();
    chk("clr_hit_ignored", 32'(av), 32'd0);
    mon = 25'h2 | (25'h10 << 15);
    step();
    mon = '0;
    step();
    chk("dual_first_valid", 32'(av), 32'd1);
    chk("dual_first_lane", 32'(al), 32'd0);
    chk("dual_first_rule", 32'(ar), 32'd1);
    chk("dual_first_ctx", 32'(ac), 32'h30);
    rdy = 1; fv = 1; fl = 3'd3;
    step();
    rdy = 0; fv = 0;
    chk("dual_accept_drop", 32'(av), 32'd0);
    chk("flagged_free_ignored", 32'(busy[3]), 32'd1);
    step();
    chk("dual_second_valid", 32'(av), 32'd1);
    chk("dual_second_lane", 32'(al), 32'd3);
    chk("dual_second_rule", 32'(ar), 32'd4);
    chk("dual_second_ctx", 32'(ac), 32'h33);
    rdy = 1;
    step();
    rdy = 0;
    chk("dual_second_drop", 32'(av), 32'd0);
    fv = 1; fl = 3'd3;
    step();
    fv = 0;
    chk("reported_free", 32'(busy[3]), 32'd0);

    mon = 25'h4 << 5;
    step();
    mon = '0;
    step();
    chk("pend_valid", 32'(av), 32'd1);
    chk("pend_lane", 32'(al), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_alert_valid", 32'(av), 32'd0);
    chk("async_lane_busy", 32'(busy), 32'h0);
    chk("async_lane_reset", 32'(lrst), 32'h1f);
    chk("async_gnt", 32'(gnt), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("post_reset_alert_lost", 32'(av), 32'd0);

    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (!(req && !m_gnt)) begin
        req = ($urandom % 3) == 0;
        ctx = 8'($urandom);
      end
      fv = ($urandom % 6) == 0;
      fl = 3'($urandom_range(0, 4));
      mon = '0;
      for (int i = 0; i < 5; i++)
        if (($urandom % 8) == 0 && !(fv && int'(fl) == i)) mon[i*5 +: 5] = 5'($urandom_range(1, 31));
      rdy = 1'($urandom % 2);
      @(posedge clk);
      model_step();
      #1;
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
